// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped, tagged branch predictor with 2-bit counters.
// Lookups are purely combinational from the table registers. Updates, the
// global history register and the statistics counters all commit on clk.
// MODE selects the index function: 0 = bimodal, 1 = gshare.
module branch_predictor #(
   parameter int ENTRIES = 16,
   parameter int TAG_W   = 8,
   parameter int PC_W    = 64,
   parameter int MODE    = 0,
   parameter int GHR_W   = 4,
   parameter int STAT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush_all,
   input  logic              lookup_valid,
   input  logic [PC_W-1:0]   lookup_pc,
   output logic              pred_hit,
   output logic              pred_taken,
   output logic [PC_W-1:0]   pred_target,
   output logic [GHR_W-1:0]  pred_ghr,
   input  logic              upd_valid,
   input  logic [PC_W-1:0]   upd_pc,
   input  logic [GHR_W-1:0]  upd_ghr,
   input  logic              upd_taken,
   input  logic [PC_W-1:0]   upd_target,
   input  logic              upd_pred_taken,
   input  logic [PC_W-1:0]   upd_pred_target,
   output logic              mispredict,
   output logic [STAT_W-1:0] stat_lookups,
   output logic [STAT_W-1:0] stat_mispredicts
);

   localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
   typedef logic [IDX_W-1:0] idx_t;

   logic [ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [PC_W-1:0]    target_q [ENTRIES];
   logic [1:0]         ctr_q    [ENTRIES];
   logic [GHR_W-1:0]   ghr_q;
   logic [STAT_W-1:0]  lookups_q;
   logic [STAT_W-1:0]  mispredicts_q;

   idx_t             lk_idx;
   idx_t             up_idx;
   logic [TAG_W-1:0] lk_tag;
   logic [TAG_W-1:0] up_tag;
   logic             up_hit;

   // PC bits outside the index/tag fields (and upd_ghr in bimodal mode) are
   // intentionally ignored.
   logic unused_bits;
   assign unused_bits = ^{lookup_pc, upd_pc, upd_ghr};

   // Index and tag extraction; lookups hash with the live GHR, updates with
   // the GHR snapshot that travelled down the pipeline with the branch.
   assign lk_idx = (MODE == 1) ? (lookup_pc[IDX_W+1:2] ^ idx_t'(ghr_q))
                               : lookup_pc[IDX_W+1:2];
   assign up_idx = (MODE == 1) ? (upd_pc[IDX_W+1:2] ^ idx_t'(upd_ghr))
                               : upd_pc[IDX_W+1:2];
   assign lk_tag = lookup_pc[IDX_W+2+TAG_W-1:IDX_W+2];
   assign up_tag = upd_pc[IDX_W+2+TAG_W-1:IDX_W+2];
   assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

   // Combinational prediction from the registered table contents.
   assign pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   assign pred_taken  = pred_hit && ctr_q[lk_idx][1];
   assign pred_target = pred_taken ? target_q[lk_idx] : (lookup_pc + PC_W'(4));
   assign pred_ghr    = ghr_q;

   // A correctly predicted not-taken branch is never a mispredict, whatever
   // the recorded target fields happen to hold.
   assign mispredict = upd_valid &&
                       ((upd_pred_taken != upd_taken) ||
                        (upd_taken && (upd_pred_target != upd_target)));

   assign stat_lookups     = lookups_q;
   assign stat_mispredicts = mispredicts_q;

   // Table and GHR: reset/flush clear state, otherwise apply the resolved branch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
         ghr_q   <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            ctr_q[i]    <= 2'b01;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
         end
      end else if (flush_all) begin
         valid_q <= '0;
         ghr_q   <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            ctr_q[i] <= 2'b01;
         end
      end else if (upd_valid) begin
         ghr_q <= (ghr_q << 1) | GHR_W'(upd_taken);
         if (up_hit) begin
            if (upd_taken) begin
               if (ctr_q[up_idx] != 2'b11) begin
                  ctr_q[up_idx] <= ctr_q[up_idx] + 2'd1;
               end
               target_q[up_idx] <= upd_target;
            end else if (ctr_q[up_idx] != 2'b00) begin
               ctr_q[up_idx] <= ctr_q[up_idx] - 2'd1;
            end
         end else if (upd_taken) begin
            valid_q[up_idx]  <= 1'b1;
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= upd_target;
            ctr_q[up_idx]    <= 2'b10;
         end
      end
   end

   // Saturating statistics; flush_all deliberately leaves these alone.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lookups_q     <= '0;
         mispredicts_q <= '0;
      end else begin
         if (lookup_valid && (lookups_q != '1)) begin
            lookups_q <= lookups_q + 1'b1;
         end
         if (mispredict && (mispredicts_q != '1)) begin
            mispredicts_q <= mispredicts_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: two predictors (bimodal default, gshare with 3-bit stats).
// Stimulus pushes hand-computed expectations; a monitor on the falling edge
// pops and compares them against the DUT outputs.
module tb_branch_predictor;

   localparam int K_HIT   = 0;
   localparam int K_TAKEN = 1;
   localparam int K_TGT   = 2;
   localparam int K_GHR   = 3;
   localparam int K_LOOK  = 4;
   localparam int K_MSTAT = 5;
   localparam int K_MISP  = 6;

   typedef struct {
      int          sel;
      int          kind;
      logic [63:0] val;
      string       name;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   logic clk = 1'b0;
   logic reset;

   logic        a_flush, a_lookup_valid, a_pred_hit, a_pred_taken;
   logic [63:0] a_lookup_pc, a_pred_target;
   logic [3:0]  a_pred_ghr, a_upd_ghr;
   logic        a_upd_valid, a_upd_taken, a_upd_pred_taken, a_mispredict;
   logic [63:0] a_upd_pc, a_upd_target, a_upd_pred_target;
   logic [31:0] a_stat_lookups, a_stat_mispredicts;

   logic        b_flush, b_lookup_valid, b_pred_hit, b_pred_taken;
   logic [63:0] b_lookup_pc, b_pred_target;
   logic [3:0]  b_pred_ghr, b_upd_ghr;
   logic        b_upd_valid, b_upd_taken, b_upd_pred_taken, b_mispredict;
   logic [63:0] b_upd_pc, b_upd_target, b_upd_pred_target;
   logic [2:0]  b_stat_lookups, b_stat_mispredicts;

   logic [3:0] ga = 4'h0;
   logic [3:0] gb = 4'h0;

   always #5 clk = ~clk;

   branch_predictor dut_a (
      .clk(clk), .reset(reset), .flush_all(a_flush),
      .lookup_valid(a_lookup_valid), .lookup_pc(a_lookup_pc),
      .pred_hit(a_pred_hit), .pred_taken(a_pred_taken),
      .pred_target(a_pred_target), .pred_ghr(a_pred_ghr),
      .upd_valid(a_upd_valid), .upd_pc(a_upd_pc), .upd_ghr(a_upd_ghr),
      .upd_taken(a_upd_taken), .upd_target(a_upd_target),
      .upd_pred_taken(a_upd_pred_taken), .upd_pred_target(a_upd_pred_target),
      .mispredict(a_mispredict), .stat_lookups(a_stat_lookups),
      .stat_mispredicts(a_stat_mispredicts)
   );

   branch_predictor #(.MODE(1), .STAT_W(3)) dut_b (
      .clk(clk), .reset(reset), .flush_all(b_flush),
      .lookup_valid(b_lookup_valid), .lookup_pc(b_lookup_pc),
      .pred_hit(b_pred_hit), .pred_taken(b_pred_taken),
      .pred_target(b_pred_target), .pred_ghr(b_pred_ghr),
      .upd_valid(b_upd_valid), .upd_pc(b_upd_pc), .upd_ghr(b_upd_ghr),
      .upd_taken(b_upd_taken), .upd_target(b_upd_target),
      .upd_pred_taken(b_upd_pred_taken), .upd_pred_target(b_upd_pred_target),
      .mispredict(b_mispredict), .stat_lookups(b_stat_lookups),
      .stat_mispredicts(b_stat_mispredicts)
   );

   function automatic logic [63:0] actual(input int sel, input int kind);
      if (sel == 0) begin
         case (kind)
            K_HIT:   return 64'(a_pred_hit);
            K_TAKEN: return 64'(a_pred_taken);
            K_TGT:   return a_pred_target;
            K_GHR:   return 64'(a_pred_ghr);
            K_LOOK:  return 64'(a_stat_lookups);
            K_MSTAT: return 64'(a_stat_mispredicts);
            default: return 64'(a_mispredict);
         endcase
      end else begin
         case (kind)
            K_HIT:   return 64'(b_pred_hit);
            K_TAKEN: return 64'(b_pred_taken);
            K_TGT:   return b_pred_target;
            K_GHR:   return 64'(b_pred_ghr);
            K_LOOK:  return 64'(b_stat_lookups);
            K_MSTAT: return 64'(b_stat_mispredicts);
            default: return 64'(b_mispredict);
         endcase
      end
   endfunction

   // Monitor: compare every queued expectation at the falling edge.
   always @(negedge clk) begin
      exp_t        e;
      logic [63:0] act;
      while (q.size() > 0) begin
         e   = q.pop_front();
         act = actual(e.sel, e.kind);
         n_cmp++;
         if (act !== e.val) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.val);
         end
      end
   end

   task automatic exp_v(input int sel, input int kind, input logic [63:0] v, input string nm);
      exp_t e;
      e.sel = sel; e.kind = kind; e.val = v; e.name = nm;
      q.push_back(e);
   endtask

   task automatic exp_look(input int sel, input logic [63:0] pc, input bit hit,
                           input bit tk, input logic [63:0] tgt, input string nm);
      if (sel == 0) a_lookup_pc = pc; else b_lookup_pc = pc;
      exp_v(sel, K_HIT, 64'(hit), {nm, ".hit"});
      exp_v(sel, K_TAKEN, 64'(tk), {nm, ".taken"});
      exp_v(sel, K_TGT, tgt, {nm, ".target"});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      a_upd_valid = 1'b0; b_upd_valid = 1'b0;
      a_flush = 1'b0; b_flush = 1'b0;
   endtask

   // Drives one resolved branch; the GHR snapshot is the bench's own history model.
   task automatic drive_upd(input int sel, input logic [63:0] pc, input bit tk,
                            input logic [63:0] tgt, input bit ptk, input logic [63:0] ptgt);
      if (sel == 0) begin
         a_upd_valid = 1'b1; a_upd_pc = pc; a_upd_ghr = ga; a_upd_taken = tk;
         a_upd_target = tgt; a_upd_pred_taken = ptk; a_upd_pred_target = ptgt;
         ga = {ga[2:0], tk};
      end else begin
         b_upd_valid = 1'b1; b_upd_pc = pc; b_upd_ghr = gb; b_upd_taken = tk;
         b_upd_target = tgt; b_upd_pred_taken = ptk; b_upd_pred_target = ptgt;
         gb = {gb[2:0], tk};
      end
   endtask

   task automatic upd_ok(input int sel, input logic [63:0] pc, input bit tk, input logic [63:0] tgt);
      drive_upd(sel, pc, tk, tgt, tk, tgt);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0;
      a_flush = 0; a_lookup_valid = 0; a_lookup_pc = 0; a_upd_valid = 0; a_upd_pc = 0;
      a_upd_ghr = 0; a_upd_taken = 0; a_upd_target = 0; a_upd_pred_taken = 0; a_upd_pred_target = 0;
      b_flush = 0; b_lookup_valid = 0; b_lookup_pc = 0; b_upd_valid = 0; b_upd_pc = 0;
      b_upd_ghr = 0; b_upd_taken = 0; b_upd_target = 0; b_upd_pred_taken = 0; b_upd_pred_target = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      // Reset state
      exp_v(0, K_GHR, 0, "rst.ghr");
      exp_v(0, K_LOOK, 0, "rst.lookups");
      exp_v(0, K_MSTAT, 0, "rst.mispredicts");
      exp_look(0, 64'h100, 0, 0, 64'h104, "rst");
      tick();

      // Allocate, then walk the counter down and back up
      upd_ok(0, 64'h100, 1, 64'h80);
      exp_look(0, 64'h100, 1, 1, 64'h80, "alloc");
      tick();
      drive_upd(0, 64'h100, 0, 64'h0, 0, 64'h0);
      exp_look(0, 64'h100, 1, 1, 64'h80, "same_cycle");
      tick();
      exp_look(0, 64'h100, 1, 0, 64'h104, "nt1");
      tick();
      upd_ok(0, 64'h100, 0, 64'h0);
      exp_look(0, 64'h100, 1, 0, 64'h104, "nt2");
      tick();
      upd_ok(0, 64'h100, 0, 64'h0);
      exp_look(0, 64'h100, 1, 0, 64'h104, "nt3_sat00");
      tick();
      upd_ok(0, 64'h100, 1, 64'h80);
      exp_look(0, 64'h100, 1, 0, 64'h104, "t1_ctr01");
      tick();
      upd_ok(0, 64'h100, 1, 64'h80);
      exp_look(0, 64'h100, 1, 1, 64'h80, "t2_ctr10");
      tick();
      upd_ok(0, 64'h100, 1, 64'h80);
      upd_ok(0, 64'h100, 1, 64'h80);
      upd_ok(0, 64'h100, 0, 64'h0);
      exp_look(0, 64'h100, 1, 1, 64'h80, "sat11_then_nt");
      exp_v(0, K_GHR, 64'hE, "ghr_bimodal");
      tick();

      // Tag alias on index 0
      exp_look(0, 64'h140, 0, 0, 64'h144, "alias_miss");
      tick();
      upd_ok(0, 64'h140, 1, 64'h200);
      exp_look(0, 64'h140, 1, 1, 64'h200, "alias_alloc");
      tick();
      exp_look(0, 64'h100, 0, 0, 64'h104, "alias_evict");
      tick();

      // Mispredict flag and counting
      drive_upd(0, 64'h140, 1, 64'h90, 1, 64'h80);
      exp_v(0, K_MISP, 1, "misp_target");
      tick();
      exp_v(0, K_MSTAT, 1, "mstat_1");
      drive_upd(0, 64'h140, 1, 64'h90, 1, 64'h90);
      exp_v(0, K_MISP, 0, "misp_correct");
      tick();
      exp_v(0, K_MSTAT, 1, "mstat_hold");
      drive_upd(0, 64'h140, 0, 64'h11, 0, 64'h22);
      exp_v(0, K_MISP, 0, "misp_nt_targets_differ");
      tick();
      drive_upd(0, 64'h140, 0, 64'h0, 1, 64'h200);
      exp_v(0, K_MISP, 1, "misp_direction");
      tick();
      exp_v(0, K_MSTAT, 2, "mstat_2");
      a_upd_pred_taken = 1'b1; a_upd_taken = 1'b0;
      exp_v(0, K_MISP, 0, "misp_no_valid");
      tick();

      // Lookup counter
      a_lookup_valid = 1'b1;
      repeat (3) tick();
      a_lookup_valid = 1'b0;
      exp_v(0, K_LOOK, 3, "lookups_3");
      tick();

      // Flush concurrent with a taken update
      drive_upd(0, 64'h100, 1, 64'h80, 1, 64'h80);
      a_flush = 1'b1;
      tick();
      ga = 4'h0;
      exp_v(0, K_GHR, 0, "flush.ghr");
      exp_v(0, K_LOOK, 3, "flush.lookups");
      exp_v(0, K_MSTAT, 2, "flush.mispredicts");
      exp_look(0, 64'h100, 0, 0, 64'h104, "flush_100");
      tick();
      exp_look(0, 64'h140, 0, 0, 64'h144, "flush_140");
      tick();
      upd_ok(0, 64'h100, 1, 64'h80);
      exp_look(0, 64'h100, 1, 1, 64'h80, "post_flush_alloc");
      tick();

      // gshare: history build-up and index selection
      upd_ok(1, 64'h300, 1, 64'h400);
      upd_ok(1, 64'h300, 1, 64'h400);
      upd_ok(1, 64'h300, 0, 64'h0);
      exp_v(1, K_GHR, 64'h6, "gs_ghr_0110");
      upd_ok(1, 64'h100, 1, 64'h80);
      exp_look(1, 64'h100, 0, 0, 64'h104, "gs_miss_ghr1101");
      tick();
      upd_ok(1, 64'h300, 0, 64'h0);
      upd_ok(1, 64'h300, 1, 64'h400);
      upd_ok(1, 64'h300, 1, 64'h400);
      upd_ok(1, 64'h300, 0, 64'h0);
      exp_v(1, K_GHR, 64'h6, "gs_ghr_back_0110");
      exp_look(1, 64'h100, 1, 1, 64'h80, "gs_hit_idx6");
      tick();
      exp_look(1, 64'h118, 0, 0, 64'h11C, "gs_idx0_untouched");
      tick();
      upd_ok(1, 64'h300, 0, 64'h0);
      exp_look(1, 64'h100, 0, 0, 64'h104, "gs_miss_ghr1100");
      tick();

      // Saturation of narrow statistics counters
      for (int i = 0; i < 6; i++) begin
         drive_upd(1, 64'h300, 0, 64'h0, 1, 64'h0);
         exp_v(1, K_MISP, 1, "b_misp");
         tick();
      end
      exp_v(1, K_MSTAT, 6, "b_mstat_6");
      drive_upd(1, 64'h300, 0, 64'h0, 1, 64'h0);
      tick();
      exp_v(1, K_MSTAT, 7, "b_mstat_7");
      for (int i = 0; i < 2; i++) begin
         drive_upd(1, 64'h300, 0, 64'h0, 1, 64'h0);
         tick();
      end
      exp_v(1, K_MSTAT, 7, "b_mstat_sat");
      b_lookup_valid = 1'b1;
      repeat (6) tick();
      exp_v(1, K_LOOK, 6, "b_lookups_6");
      repeat (3) tick();
      b_lookup_valid = 1'b0;
      exp_v(1, K_LOOK, 7, "b_lookups_sat");
      tick();

      // Asynchronous reset between edges, with an update in flight
      drive_upd(0, 64'h100, 1, 64'hC0, 1, 64'hC0);
      #1 reset = 1'b0;
      exp_v(0, K_GHR, 0, "async_rst.ghr");
      exp_v(0, K_LOOK, 0, "async_rst.lookups");
      exp_v(0, K_MSTAT, 0, "async_rst.mispredicts");
      exp_v(1, K_GHR, 0, "async_rst.b_ghr");
      exp_v(1, K_MSTAT, 0, "async_rst.b_mispredicts");
      exp_look(0, 64'h100, 0, 0, 64'h104, "async_rst");
      @(negedge clk);
      #1;
      ga = 4'h0; gb = 4'h0;
      @(posedge clk);
      #1;
      a_upd_valid = 1'b0;
      reset = 1'b1;
      exp_look(0, 64'h100, 0, 0, 64'h104, "rst_discard");
      tick();

      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the 64-bit RISC-V pipeline, replacing static not-taken fetch. IF queries it every cycle with the fetch PC and receives a predicted direction and target. EX writes back resolved branch outcomes. Supports bimodal and gshare indexing, tagged BTB entries with 2-bit saturating counters, a non-speculative global history register, and saturating lookup/mispredict statistics counters.

## Interface

- ENTRIES, 16, table depth; power of two ≥ 2; IDX_W = log2(ENTRIES)
- TAG_W, 8, tag width; tag = pc[IDX_W+2+TAG_W-1 : IDX_W+2]
- PC_W, 64, PC and target width
- MODE, 0, indexing: 0 = bimodal, 1 = gshare
- GHR_W, 4, global history width; must be ≥ IDX_W when MODE=1
- STAT_W, 32, statistics counter width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- flush_all  in  1  synchronous clear of all entries and the GHR
- lookup_valid  in  1  IF lookup this cycle; gates the lookup counter only
- lookup_pc  in  PC_W  fetch PC
- pred_hit  out  1  valid entry with matching tag
- pred_taken  out  1  predicted taken
- pred_target  out  PC_W  predicted next PC
- pred_ghr  out  GHR_W  current GHR; pipeline carries it to EX
- upd_valid  in  1  resolved conditional branch this cycle
- upd_pc  in  PC_W  branch PC
- upd_ghr  in  GHR_W  pred_ghr captured at this branch's lookup
- upd_taken  in  1  actual direction
- upd_target  in  PC_W  actual taken target
- upd_pred_taken  in  1  direction predicted at lookup
- upd_pred_target  in  PC_W  target predicted at lookup
- mispredict  out  1  combinational mispredict flag for the update
- stat_lookups  out  STAT_W  lookup count, saturating
- stat_mispredicts  out  STAT_W  mispredict count, saturating

## Operation

- Entry fields: valid, tag[TAG_W], target[PC_W], ctr[2].
- Index: bimodal = pc[IDX_W+1:2]; gshare = pc[IDX_W+1:2] XOR ghr[IDX_W-1:0].
  - Lookups use the live GHR.
  - Updates use upd_ghr.
- Lookup is combinational from the table registers:
  - pred_hit = valid && tag match.
  - pred_taken = pred_hit && ctr[1].
  - pred_target = target when pred_taken, else lookup_pc + 4, wrapping modulo 2^PC_W.
- Update, on upd_valid, at the indexed entry:
  - Hit, taken: ctr increments, saturating at 11; target <= upd_target.
  - Hit, not taken: ctr decrements, saturating at 00; target unchanged.
  - Miss, taken: allocate (replacing any occupant): valid=1, tag, target=upd_target, ctr=10.
  - Miss, not taken: no write.
- GHR: on each upd_valid, ghr <= {ghr[GHR_W-2:0], upd_taken}. Lookups never change the GHR.
- mispredict = upd_valid && (upd_pred_taken != upd_taken || (upd_taken && upd_pred_target != upd_target)).
- Statistics:
  - stat_lookups increments on lookup_valid.
  - stat_mispredicts increments on mispredict.
  - Both hold at all-ones once saturated.
- flush_all: clears every valid bit, resets every ctr to 01, and sets GHR to 0. It overrides a same-cycle update. Statistics are not cleared.

## Timing

- Reset (asynchronous assert; release synchronous to clk): all valid=0, all ctr=01, GHR=0, both statistics counters=0.
  - Outputs after reset: pred_hit=0, pred_taken=0, pred_target=lookup_pc+4, pred_ghr=0.
  - Reset asserted mid-update discards that update.
- Lookup latency is 0 cycles (same cycle as lookup_pc).
- Update latency is 1 cycle: the table, GHR and counters change at the clk edge where upd_valid=1. The change is visible to lookups from the next cycle.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update contents.
- Back-to-back updates to one entry on consecutive cycles each apply in order; none are lost.
- mispredict is combinational in the upd_valid cycle. The stat_mispredicts increment becomes visible the next cycle.
- No stall input: the pipeline holds lookup_pc during stalls and asserts upd_valid exactly once per resolved branch.

## Test plan

- Reset state (default params): lookup 0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104, pred_ghr=0, both statistics counters 0.
- Allocate, then saturate:
  - Update pc=0x100, taken, target 0x80 -> next cycle lookup 0x100 gives hit=1, taken=1, target=0x80.
  - Then 3 not-taken updates -> ctr 01, 00, 00; pred_taken=0 from the first of them.
  - Then 4 taken updates -> ctr 01, 10, 11, 11.
- Tag alias: 0x100 allocated; lookup 0x140 (same index 0, tag 5 vs 4) -> hit=0, target=0x144. Taken update on 0x140 with target 0x200 replaces the entry, after which lookup 0x100 misses.
- Mispredict counting: upd_pred_taken=1, upd_taken=1, upd_pred_target=0x80, upd_target=0x90 -> mispredict=1 and stat_mispredicts +1. A correct update -> mispredict=0 and no increment. Preload the counter to within 1 of all-ones; further mispredicts hold it at 0xFFFFFFFF.
- gshare (MODE=1):
  - Updates taken, taken, not-taken from GHR=0 -> pred_ghr = 0b0110.
  - Taken update on pc=0x100 with upd_ghr=0b0110 writes index 6 only.
  - Lookup 0x100 hits only while the live GHR = 0b0110.
- Flush and reset:
  - flush_all concurrent with a taken update -> next cycle all lookups miss, GHR=0, statistics retained.
  - Assert reset mid-sequence between edges -> outputs return to reset values immediately, with no clock edge needed.
